// File: rtl/feeder_pkg.sv
// Shared types and default sizes for the systolic edge feeder.
// The optional stall counter is enabled with FEEDER_STALL_CNT_EN.
package feeder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_e;

    localparam int DEF_N  = 4;
    localparam int DEF_DW = 8;
    localparam int DEF_KW = 8;

endpackage

// File: rtl/skew_delay_line.sv
// Per-lane fire/data delay of DEPTH cycles with async clear.
// DEPTH=0 passes the lane-0 stage register straight through.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          fire_i,
    input  logic [DW-1:0] data_i,
    output logic          fire_o,
    output logic [DW-1:0] data_o
);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk;
        assign unused_clk = clk ^ rstn;
        assign fire_o = fire_i;
        assign data_o = data_i;
    end else begin : g_shift
        logic [DEPTH-1:0]         fire_q;
        logic [DEPTH-1:0][DW-1:0] data_q;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                fire_q <= '0;
                data_q <= '0;
            end else begin
                fire_q[0] <= fire_i;
                data_q[0] <= data_i;
                for (int k = 1; k < DEPTH; k++) begin
                    fire_q[k] <= fire_q[k-1];
                    data_q[k] <= data_q[k-1];
                end
            end
        end

        assign fire_o = fire_q[DEPTH-1];
        assign data_o = data_q[DEPTH-1];
    end

endmodule

// File: rtl/systolic_feeder.sv
// Streams K-deep operand columns onto N PE lanes with a diagonal skew.
// Define FEEDER_STALL_CNT_EN to add the stall_cnt output.
module systolic_feeder
    import feeder_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW,
    parameter int KW = DEF_KW
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [N*DW-1:0] s_data,
    output logic [N-1:0]    out_fire,
    output logic [N*DW-1:0] out_data,
    output logic            busy,
`ifdef FEEDER_STALL_CNT_EN
    output logic [15:0]     stall_cnt,
`endif
    output logic            done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'((N > 1) ? N - 2 : 0);

    state_e state_q, state_d;
    logic [KW-1:0] klen_q, klen_d;
    logic [KW-1:0] beat_q, beat_d;
    logic [CW-1:0] drain_q, drain_d;

    logic            fire0_q;
    logic [N*DW-1:0] data0_q;
    logic            accept;

    assign s_ready = (state_q == STREAM);
    assign accept  = s_ready && s_valid;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            klen_q  <= '0;
            beat_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        klen_d  = klen_q;
        beat_d  = beat_q;
        drain_d = drain_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    klen_d  = k_len;
                    beat_d  = '0;
                    state_d = (k_len != '0) ? STREAM : DONE;
                end
            end
            STREAM: begin
                if (accept) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == klen_q - 1'b1) begin
                        drain_d = '0;
                        state_d = (N > 1) ? DRAIN : DONE;
                    end
                end
            end
            DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == DRAIN_LAST) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage register shared by every lane; data holds across bubbles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fire0_q <= 1'b0;
            data0_q <= '0;
        end else begin
            fire0_q <= accept;
            if (accept) data0_q <= s_data;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_delay_line #(
            .DEPTH (i),
            .DW    (DW)
        ) u_skew (
            .clk    (clk),
            .rstn   (rstn),
            .fire_i (fire0_q),
            .data_i (data0_q[i*DW +: DW]),
            .fire_o (out_fire[i]),
            .data_o (out_data[i*DW +: DW])
        );
    end

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_q <= '0;
        end else if (state_q == IDLE && start) begin
            stall_q <= '0;
        end else if (state_q == STREAM && !s_valid && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomised scoreboard bench for systolic_feeder.
// Covers the stall counter when FEEDER_STALL_CNT_EN is defined.
module tb_systolic_feeder;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int KW = 8;

    typedef struct {
        int            cyc;
        logic [DW-1:0] d;
    } exp_t;

    logic            clk;
    logic            rstn;
    logic            start;
    logic [KW-1:0]   k_len;
    logic            s_valid;
    logic            s_ready;
    logic [N*DW-1:0] s_data;
    logic [N-1:0]    out_fire;
    logic [N*DW-1:0] out_data;
    logic            busy;
    logic            done;
`ifdef FEEDER_STALL_CNT_EN
    logic [15:0]     stall_cnt;
`endif

    systolic_feeder #(.N(N), .DW(DW), .KW(KW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .k_len     (k_len),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .out_fire  (out_fire),
        .out_data  (out_data),
        .busy      (busy),
`ifdef FEEDER_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .done      (done)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic exp_busy;
    logic exp_ready;
    exp_t lq[N][$];
    int   done_q[$];
    exp_t me;
    int   dc;
    logic [31:0] tbl_a [3] = '{32'h01020304, 32'h05060708, 32'h090A0B0C};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected beats/done pulses whenever the DUT presents them.
    always @(negedge clk) begin
        if (rstn) begin
            for (int i = 0; i < N; i++) begin
                if (out_fire[i]) begin
                    if (lq[i].size() == 0) begin
                        chk($sformatf("lane%0d_spurious_fire", i), 1, 0);
                    end else begin
                        me = lq[i].pop_front();
                        chk($sformatf("lane%0d_fire_edge", i), 64'(me.cyc), 64'(cyc));
                        chk($sformatf("lane%0d_data", i), out_data[i*DW +: DW], me.d);
                    end
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    dc = done_q.pop_front();
                    chk("done_edge", 64'(cyc), 64'(dc));
                end
            end
            chk("busy", busy, exp_busy);
            chk("s_ready", s_ready, exp_ready);
        end
    end

    task automatic check_quiet(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_out_fire"}, out_fire, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Reference: a beat offered in a stream cycle is taken at the next edge
    // and shows on lane i i edges later; done follows the last beat by N-1.
    task automatic run_job(input int k, input int vpct, input logic [31:0] bmask,
                           input bit use_tbl, input int abort_at, input bit start_in_drain);
        int acc, j, sc, last, e0;
        logic v;
        exp_t e;
        start = 1'b1;
        k_len = KW'(k);
        tick();
        e0 = cyc;
        start = 1'b0;
        exp_busy = 1'b1;
`ifdef FEEDER_STALL_CNT_EN
        chk("stall_cnt_clear_on_start", stall_cnt, 0);
`endif
        if (k == 0) begin
            done_q.push_back(e0);
            tick();
            exp_busy = 1'b0;
`ifdef FEEDER_STALL_CNT_EN
            chk("stall_cnt_zero_job", stall_cnt, 0);
`endif
            return;
        end
        exp_ready = 1'b1;
        acc = 0;
        j = 0;
        sc = 0;
        last = e0;
        while (acc < k) begin
            if (j < 32 && bmask[j]) v = 1'b0;
            else v = ($urandom_range(99) < vpct);
            if (j >= 200) v = 1'b1;
            s_valid = v;
            s_data  = use_tbl ? tbl_a[acc % 3] : $urandom;
            k_len   = KW'($urandom);
            if (!v) sc++;
            tick();
            j++;
            if (v) begin
                for (int i = 0; i < N; i++) begin
                    e.cyc = cyc + i;
                    e.d   = s_data[i*DW +: DW];
                    lq[i].push_back(e);
                end
                acc++;
                last = cyc;
            end
            if (abort_at >= 0 && acc == abort_at) begin
                #2;
                rstn = 1'b0;
                s_valid = 1'b0;
                exp_busy = 1'b0;
                exp_ready = 1'b0;
                for (int i = 0; i < N; i++) lq[i].delete();
                done_q.delete();
                #1;
                check_quiet("async_reset");
                tick();
                rstn = 1'b1;
                repeat (4) tick();
                chk("post_reset_out_fire", out_fire, 0);
                chk("post_reset_out_data", out_data, 0);
                return;
            end
        end
        s_valid = 1'b0;
        exp_ready = 1'b0;
        done_q.push_back(last + N - 1);
        if (start_in_drain && N > 1) begin
            start = 1'b1;
            k_len = KW'(5);
            tick();
            start = 1'b0;
        end
        while (cyc < last + N) tick();
        exp_busy = 1'b0;
`ifdef FEEDER_STALL_CNT_EN
        chk("stall_cnt_after_done", stall_cnt, (sc > 65535) ? 65535 : sc);
`endif
    endtask

    initial begin
        rstn = 1'b0;
        start = 1'b0;
        k_len = '0;
        s_valid = 1'b0;
        s_data = '0;
        exp_busy = 1'b0;
        exp_ready = 1'b0;
        #2;
        check_quiet("reset");
`ifdef FEEDER_STALL_CNT_EN
        chk("reset_stall_cnt", stall_cnt, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();

        run_job(3, 100, 32'h0, 1'b1, -1, 1'b0);
        run_job(3, 100, 32'h2, 1'b1, -1, 1'b0);
        run_job(0, 100, 32'h0, 1'b0, -1, 1'b0);
        run_job(4, 100, 32'h0, 1'b0, -1, 1'b1);
        run_job(6, 100, 32'h0, 1'b0, 2, 1'b0);
        run_job(2, 100, 32'h1F, 1'b0, -1, 1'b0);
        run_job(3, 100, 32'h0, 1'b0, -1, 1'b0);
        for (int n = 0; n < 25; n++) begin
            run_job($urandom_range(12), $urandom_range(100, 40), 32'h0, 1'b0,
                    -1, 1'($urandom_range(1)));
            repeat ($urandom_range(2)) tick();
        end
        run_job(1, 100, 32'h0, 1'b0, -1, 1'b0);
        repeat (N + 2) tick();

        for (int i = 0; i < N; i++) chk($sformatf("lane%0d_pending_beats", i), lq[i].size(), 0);
        chk("pending_done", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
